// File: rtl/mem_io_pkg.sv
// Shared address map for the memory/I-O responder: I/O register addresses,
// upper-address decode fields and the region decoder used by the top.
package mem_io_pkg;

  localparam logic [17:0] IO_UART        = 18'h30000;
  localparam logic [17:0] IO_CLK         = 18'h30004;
  localparam logic [1:0]  IO_FIELD       = 2'b11;
  localparam logic [1:0]  UNMAPPED_FIELD = 2'b10;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_UNMAPPED
  } region_e;

  function automatic region_e decode_region(input logic [17:0] addr);
    case (addr[17:16])
      IO_FIELD:       return REGION_IO;
      UNMAPPED_FIELD: return REGION_UNMAPPED;
      default:        return REGION_RAM;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with occupancy count; a pop in the same cycle
// frees a slot so a push into a full FIFO is still accepted.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-bus responder: 128 KB RAM with registered reads, plus the I/O window
// holding UART tx/rx FIFOs, the free-running cycle counter and program stop.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    RAM_ADDR_WIDTH = 17,
  parameter int    TX_DEPTH       = 8,
  parameter int    RX_DEPTH       = 8,
  parameter string INIT_FILE      = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        stopped,
  output logic        tx_overflow
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  logic [7:0] ram [2**RAM_ADDR_WIDTH];

  logic [17:0]               addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  region_e                   region;
  logic                      bus_rd, bus_wr, win_sel;
  logic                      uart_rd, uart_wr, clk_rd, stop_wr, ram_we;
  logic                      tx_push, tx_full, tx_empty, rx_push, rx_full, rx_empty;
  logic [7:0]                tx_din, rx_dout, io_rdata;
  logic [TXCW-1:0]           tx_count;
  logic [RXCW-1:0]           rx_count;
  logic [31:0]               cycle_cnt, snapshot;
  logic                      unused_bits;

  assign addr     = cpu_a[17:0];
  assign ram_addr = cpu_a[RAM_ADDR_WIDTH-1:0];
  assign region   = decode_region(addr);
  assign bus_rd   = rdy_in && !cpu_wr;
  assign bus_wr   = rdy_in && cpu_wr;
  assign win_sel  = (addr[17:3] == IO_UART[17:3]);
  assign uart_rd  = bus_rd && (addr == IO_UART);
  assign uart_wr  = bus_wr && (addr == IO_UART);
  assign clk_rd   = bus_rd && (addr == IO_CLK);
  assign stop_wr  = bus_wr && (addr == IO_CLK);
  assign ram_we   = bus_wr && (region == REGION_RAM);

  // A stop write injects a 0x00 marker that bypasses the zero filter on data writes.
  assign tx_push  = (uart_wr && (cpu_dout != 8'h00)) || stop_wr;
  assign tx_din   = stop_wr ? 8'h00 : cpu_dout;
  assign rx_push  = rx_valid && rx_ready;

  assign tx_valid       = !tx_empty;
  assign rx_ready       = !rx_full;
  assign io_buffer_full = (tx_count >= TXCW'(TX_DEPTH - 1));
  assign unused_bits    = ^{cpu_a[31:18], rx_count};

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .din    (tx_din),
    .pop    (tx_ready),
    .dout   (tx_data),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_push),
    .din    (rx_data),
    .pop    (uart_rd),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= cpu_dout;
  end

  // Reading 0x30004 returns the live counter's low byte, which is what the snapshot captures.
  always_comb begin
    io_rdata = 8'h00;
    if (win_sel) begin
      case (addr[2:0])
        3'd0:    io_rdata = rx_empty ? 8'h00 : rx_dout;
        3'd4:    io_rdata = cycle_cnt[7:0];
        3'd5:    io_rdata = snapshot[15:8];
        3'd6:    io_rdata = snapshot[23:16];
        3'd7:    io_rdata = snapshot[31:24];
        default: io_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cpu_din      <= 8'h00;
      cycle_cnt    <= 32'd0;
      snapshot     <= 32'd0;
      program_stop <= 1'b0;
      stopped      <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      cycle_cnt    <= cycle_cnt + 32'd1;
      program_stop <= stop_wr;
      if (stop_wr) stopped <= 1'b1;
      if (tx_push && tx_full && !tx_ready) tx_overflow <= 1'b1;
      if (clk_rd) snapshot <= cycle_cnt;
      if (bus_rd) begin
        case (region)
          REGION_RAM: cpu_din <= ram[ram_addr];
          REGION_IO:  cpu_din <= io_rdata;
          default:    cpu_din <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a vector table for RAM/decode reads plus
// hand-written sequences for UART FIFOs, cycle counter, stop, rdy_in and reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] cpu_a = 32'h20000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_stop;
  logic        stopped;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;
  int edges;
  logic [7:0] tx_seen[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  dout;
    logic        chk;
    logic [7:0]  exp_din;
    string       name;
  } vec_t;

  vec_t vecs[12];

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_stop   (program_stop),
    .stopped        (stopped),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle count: edges seen since reset was released.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) edges <= 0;
    else         edges <= edges + 1;
  end

  // Inputs only change 1 time unit after posedge, so negedge values are what the next edge sees.
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic wr, input logic [31:0] addr, input logic [7:0] dout);
    rdy_in   = rdy;
    cpu_wr   = wr;
    cpu_a    = addr;
    cpu_dout = dout;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h20000, 8'h00);
  endtask

  task automatic wait_edges(input int target);
    int guard = 0;
    rdy_in = 1'b1; cpu_wr = 1'b0; cpu_a = 32'h20000;
    while (edges < target && guard < 2000) begin
      @(posedge clk_in);
      #1;
      guard++;
    end
    checkOutput($sformatf("wait_edges_%0d", target), edges, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_cpu_din"}, cpu_din, 8'h00);
    checkOutput({tag, "_tx_valid"}, tx_valid, 1'b0);
    checkOutput({tag, "_io_buffer_full"}, io_buffer_full, 1'b0);
    checkOutput({tag, "_rx_ready"}, rx_ready, 1'b1);
    checkOutput({tag, "_program_stop"}, program_stop, 1'b0);
    checkOutput({tag, "_stopped"}, stopped, 1'b0);
    checkOutput({tag, "_tx_overflow"}, tx_overflow, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_b;
    logic [7:0] exp_tx[9];
    logic [7:0] exp_rx[8];
    int         snap_val;

    vecs[0]  = '{1'b1, 32'h00010, 8'hA5, 1'b0, 8'h00, "wr_ram_10"};
    vecs[1]  = '{1'b0, 32'h00010, 8'h00, 1'b1, 8'hA5, "rd_ram_10"};
    vecs[2]  = '{1'b0, 32'h20000, 8'h00, 1'b1, 8'h00, "rd_unmapped"};
    vecs[3]  = '{1'b1, 32'h00011, 8'h3C, 1'b0, 8'h00, "wr_ram_11"};
    vecs[4]  = '{1'b0, 32'h00011, 8'h00, 1'b1, 8'h3C, "rd_ram_11"};
    vecs[5]  = '{1'b0, 32'h00010, 8'h00, 1'b1, 8'hA5, "rd_ram_10_again"};
    vecs[6]  = '{1'b1, 32'h10000, 8'h77, 1'b0, 8'h00, "wr_ram_bank1"};
    vecs[7]  = '{1'b0, 32'h10000, 8'h00, 1'b1, 8'h77, "rd_ram_bank1"};
    vecs[8]  = '{1'b1, 32'h20000, 8'hFF, 1'b0, 8'h00, "wr_unmapped"};
    vecs[9]  = '{1'b0, 32'h20000, 8'h00, 1'b1, 8'h00, "rd_unmapped_after_wr"};
    vecs[10] = '{1'b0, 32'h30003, 8'h00, 1'b1, 8'h00, "rd_io_undefined"};
    vecs[11] = '{1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rd_rx_empty"};

    // Reset: a real falling edge so the async reset fires.
    #2 rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b1;

    // Cycle counter and snapshot.
    wait_edges(100);
    applyStimulus(1'b1, 1'b0, 32'h30004, 8'h00);
    checkOutput("cnt100_b0", cpu_din, 8'd100);
    applyStimulus(1'b1, 1'b0, 32'h30005, 8'h00);
    checkOutput("cnt100_b1", cpu_din, 8'h00);
    applyStimulus(1'b1, 1'b0, 32'h30006, 8'h00);
    checkOutput("cnt100_b2", cpu_din, 8'h00);
    applyStimulus(1'b1, 1'b0, 32'h30007, 8'h00);
    checkOutput("cnt100_b3", cpu_din, 8'h00);
    wait_edges(300);
    applyStimulus(1'b1, 1'b0, 32'h30004, 8'h00);
    checkOutput("cnt300_b0", cpu_din, 8'h2C);
    wait_edges(600);
    applyStimulus(1'b1, 1'b0, 32'h30005, 8'h00);
    checkOutput("snap_no_relatch_b1", cpu_din, 8'h01);
    snap_val = edges;
    applyStimulus(1'b1, 1'b0, 32'h30004, 8'h00);
    checkOutput("relatch_b0", cpu_din, 32'(snap_val & 8'hFF));
    applyStimulus(1'b1, 1'b0, 32'h30005, 8'h00);
    checkOutput("relatch_b1", cpu_din, 32'((snap_val >> 8) & 8'hFF));

    // RAM and decode vector table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].dout);
      if (vecs[i].chk) checkOutput(vecs[i].name, cpu_din, vecs[i].exp_din);
    end

    // UART tx with zero filter.
    tx_seen.delete();
    tx_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h30000, 8'h41);
    applyStimulus(1'b1, 1'b1, 32'h30000, 8'h00);
    applyStimulus(1'b1, 1'b1, 32'h30000, 8'h42);
    idle(4);
    checkOutput("tx_emit_count", tx_seen.size(), 2);
    if (tx_seen.size() == 2) begin
      checkOutput("tx_emit_0", tx_seen[0], 8'h41);
      checkOutput("tx_emit_1", tx_seen[1], 8'h42);
    end

    // Fill tx with the UART stalled, then push/pop simultaneously while full.
    tx_ready = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h30000, 8'(8'h50 + i));
      if (i == 5) checkOutput("tx_full_flag_at6", io_buffer_full, 1'b0);
      if (i == 6) checkOutput("tx_full_flag_at7", io_buffer_full, 1'b1);
      if (i == 7) checkOutput("tx_overflow_at8", tx_overflow, 1'b0);
      if (i == 8) checkOutput("tx_overflow_at9", tx_overflow, 1'b1);
    end
    tx_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h30000, 8'h59);
    checkOutput("tx_full_after_swap", io_buffer_full, 1'b1);
    idle(10);
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_tx[i] = 8'(8'h50 + i);
    exp_tx[8] = 8'h59;
    checkOutput("tx_drain_count", tx_seen.size(), 9);
    for (int i = 0; i < 9 && i < tx_seen.size(); i++)
      checkOutput($sformatf("tx_drain_%0d", i), tx_seen[i], exp_tx[i]);

    // UART rx.
    rx_valid = 1'b1; rx_data = 8'h33; idle(1);
    rx_data = 8'h34; idle(1);
    rx_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h30000, 8'h00);
    checkOutput("rx_pop_0", cpu_din, 8'h33);
    applyStimulus(1'b1, 1'b0, 32'h30000, 8'h00);
    checkOutput("rx_pop_1", cpu_din, 8'h34);
    applyStimulus(1'b1, 1'b0, 32'h30000, 8'h00);
    checkOutput("rx_pop_empty", cpu_din, 8'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'h60 + i);
      idle(1);
      if (i == 6) checkOutput("rx_ready_at7", rx_ready, 1'b1);
      if (i == 7) checkOutput("rx_ready_at8", rx_ready, 1'b0);
    end
    rx_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h30000, 8'h00);
    checkOutput("rx_pop_after_fill", cpu_din, 8'h60);
    rx_valid = 1'b1; rx_data = 8'h70;
    applyStimulus(1'b1, 1'b0, 32'h30000, 8'h00);
    checkOutput("rx_swap_data", cpu_din, 8'h61);
    checkOutput("rx_swap_ready", rx_ready, 1'b1);
    rx_data = 8'h71; idle(1);
    rx_valid = 1'b0;
    checkOutput("rx_ready_refull", rx_ready, 1'b0);
    exp_rx = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h70, 8'h71};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h30000, 8'h00);
      checkOutput($sformatf("rx_drain_%0d", i), cpu_din, exp_rx[i]);
    end

    // Program stop.
    tx_seen.delete();
    applyStimulus(1'b1, 1'b1, 32'h30004, 8'hAB);
    checkOutput("stop_pulse", program_stop, 1'b1);
    checkOutput("stop_sticky", stopped, 1'b1);
    checkOutput("stop_tx_valid", tx_valid, 1'b1);
    checkOutput("stop_tx_data", tx_data, 8'h00);
    idle(1);
    checkOutput("stop_pulse_end", program_stop, 1'b0);
    checkOutput("stop_still_set", stopped, 1'b1);
    tx_ready = 1'b1; idle(2); tx_ready = 1'b0;
    checkOutput("stop_marker_count", tx_seen.size(), 1);
    if (tx_seen.size() == 1) checkOutput("stop_marker_val", tx_seen[0], 8'h00);

    // rdy_in low: no RAM write, no rx pop, cpu_din held.
    applyStimulus(1'b1, 1'b1, 32'h00020, 8'h11);
    rx_valid = 1'b1; rx_data = 8'h77;
    applyStimulus(1'b1, 1'b0, 32'h00020, 8'h00);
    rx_valid = 1'b0;
    checkOutput("rdy_base_read", cpu_din, 8'h11);
    applyStimulus(1'b0, 1'b1, 32'h00020, 8'h99);
    checkOutput("rdy_low_wr_hold", cpu_din, 8'h11);
    applyStimulus(1'b0, 1'b0, 32'h30000, 8'h00);
    checkOutput("rdy_low_rd_hold", cpu_din, 8'h11);
    applyStimulus(1'b0, 1'b1, 32'h30004, 8'h00);
    checkOutput("rdy_low_no_stop", program_stop, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h00020, 8'h00);
    checkOutput("rdy_ram_unchanged", cpu_din, 8'h11);
    applyStimulus(1'b1, 1'b0, 32'h30000, 8'h00);
    checkOutput("rdy_rx_not_popped", cpu_din, 8'h77);

    // Async reset in the middle of a tx burst.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h30000, 8'(8'h21 + i));
    checkOutput("pre_reset_tx_valid", tx_valid, 1'b1);
    #3 rst_in = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    idle(2);
    checkOutput("post_reset_tx_empty", tx_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
